// File: rtl/tm_sequencer.sv
// Host-side controller that loads a transition table into a TuringMachine core
// and then steps it singly or free-running until halt or step limit.
module tm_sequencer #(
  parameter int unsigned PROG_LEN   = 32,
  parameter int unsigned SETUP      = 3,
  parameter int unsigned PULSE      = 2,
  parameter int unsigned GAP        = 2,
  parameter int unsigned SETTLE     = 4,
  parameter logic [5:0]  HALT_STATE = 6'd63,
  parameter int unsigned STEP_W     = 8,
  parameter int unsigned MAX_STEPS  = 255
) (
  input  logic              clock,
  input  logic              Reset_n,
  input  logic              load_valid,
  input  logic [3:0]        load_data,
  output logic              load_ready,
  input  logic              step,
  input  logic              run,
  input  logic              restart,
  input  logic [5:0]        next_state_out,
  input  logic [1:0]        direction,
  input  logic [5:0]        data_reg_out,
  output logic              tm_reset,
  output logic [3:0]        input_data,
  output logic              Next,
  output logic              Done,
  output logic [5:0]        state_q,
  output logic [1:0]        dir_q,
  output logic [5:0]        tape_q,
  output logic [5:0]        prog_count,
  output logic [STEP_W-1:0] step_count,
  output logic              halted,
  output logic              timeout,
  output logic              busy
);

  localparam int unsigned CntW = 8;

  typedef enum logic [3:0] {
    StTmRst, StLoadWait, StLoadSetup, StLoadPulse, StLoadGap,
    StDonePulse, StDoneGap, StReady, StRunPulse, StRunSettle, StHalted
  } fsm_e;

  fsm_e              fsm_q, fsm_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              auto_q, auto_d;
  logic [3:0]        input_data_d;
  logic [5:0]        prog_count_d, state_smp_d, tape_smp_d;
  logic [1:0]        dir_smp_d;
  logic [STEP_W-1:0] step_count_d;
  logic              halted_d, timeout_d, tm_reset_d, next_d, done_d, busy_d;

  assign load_ready = (fsm_q == StLoadWait);

  always_comb begin
    fsm_d        = fsm_q;
    cnt_d        = cnt_q + CntW'(1);
    auto_d       = auto_q;
    input_data_d = input_data;
    prog_count_d = prog_count;
    step_count_d = step_count;
    state_smp_d  = state_q;
    dir_smp_d    = dir_q;
    tape_smp_d   = tape_q;
    halted_d     = halted;
    timeout_d    = timeout;

    unique case (fsm_q)
      StTmRst:     if (cnt_q == CntW'(1)) fsm_d = StLoadWait;
      StLoadWait: begin
        if (load_valid) begin
          input_data_d = load_data;
          prog_count_d = prog_count + 6'd1;
          fsm_d        = StLoadSetup;
        end
      end
      StLoadSetup: if (cnt_q == CntW'(SETUP - 1)) fsm_d = StLoadPulse;
      StLoadPulse: if (cnt_q == CntW'(PULSE - 1)) fsm_d = StLoadGap;
      StLoadGap: begin
        if (cnt_q == CntW'(GAP - 1)) begin
          fsm_d = (prog_count == 6'(PROG_LEN)) ? StDonePulse : StLoadWait;
        end
      end
      StDonePulse: if (cnt_q == CntW'(PULSE - 1)) fsm_d = StDoneGap;
      StDoneGap:   if (cnt_q == CntW'(GAP - 1)) fsm_d = StReady;
      StReady: begin
        if (run) begin
          auto_d = 1'b1;
          fsm_d  = StRunPulse;
        end else if (step) begin
          fsm_d = StRunPulse;
        end
      end
      StRunPulse:  if (cnt_q == CntW'(PULSE - 1)) fsm_d = StRunSettle;
      StRunSettle: begin
        if (cnt_q == CntW'(SETTLE - 1)) begin
          state_smp_d  = next_state_out;
          dir_smp_d    = direction;
          tape_smp_d   = data_reg_out;
          step_count_d = (step_count == '1) ? step_count : step_count + STEP_W'(1);
          if (next_state_out == HALT_STATE) begin
            halted_d = 1'b1;
            fsm_d    = StHalted;
          end else if (auto_q && step_count_d == STEP_W'(MAX_STEPS)) begin
            timeout_d = 1'b1;
            fsm_d     = StHalted;
          end else if (auto_q) begin
            fsm_d = StRunPulse;
          end else begin
            fsm_d = StReady;
          end
        end
      end
      StHalted:    fsm_d = StHalted;
      default:     fsm_d = StTmRst;
    endcase

    // Restart wins over every transition decided above.
    if (restart && fsm_q != StTmRst) begin
      fsm_d        = StTmRst;
      auto_d       = 1'b0;
      input_data_d = '0;
      prog_count_d = '0;
      step_count_d = '0;
      state_smp_d  = '0;
      dir_smp_d    = '0;
      tape_smp_d   = '0;
      halted_d     = 1'b0;
      timeout_d    = 1'b0;
    end

    if (fsm_d != fsm_q) cnt_d = '0;

    // Strobes are registered from the next state so they track it with no lag.
    tm_reset_d = (fsm_d == StTmRst);
    next_d     = (fsm_d == StLoadPulse) || (fsm_d == StRunPulse);
    done_d     = (fsm_d == StDonePulse);
    busy_d     = !((fsm_d == StLoadWait) || (fsm_d == StReady) || (fsm_d == StHalted));
  end

  always_ff @(posedge clock) begin
    if (!Reset_n) begin
      fsm_q      <= StTmRst;
      cnt_q      <= '0;
      auto_q     <= 1'b0;
      tm_reset   <= 1'b1;
      input_data <= '0;
      Next       <= 1'b0;
      Done       <= 1'b0;
      state_q    <= '0;
      dir_q      <= '0;
      tape_q     <= '0;
      prog_count <= '0;
      step_count <= '0;
      halted     <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      cnt_q      <= cnt_d;
      auto_q     <= auto_d;
      tm_reset   <= tm_reset_d;
      input_data <= input_data_d;
      Next       <= next_d;
      Done       <= done_d;
      state_q    <= state_smp_d;
      dir_q      <= dir_smp_d;
      tape_q     <= tape_smp_d;
      prog_count <= prog_count_d;
      step_count <= step_count_d;
      halted     <= halted_d;
      timeout    <= timeout_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_tm_sequencer.sv
// Directed bench for tm_sequencer with a small behavioural TuringMachine core model.
module tb_tm_sequencer;

  logic       clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic       load_valid = 1'b0;
  logic [3:0] load_data = '0;
  logic       load_ready;
  logic       step = 1'b0, run = 1'b0, restart = 1'b0;
  logic [5:0] next_state_out, data_reg_out;
  logic [1:0] direction;
  logic       tm_reset, Next, Done, halted, timeout, busy;
  logic [3:0] input_data;
  logic [5:0] state_q, tape_q, prog_count;
  logic [1:0] dir_q;
  logic [7:0] step_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  tm_sequencer #(.HALT_STATE(6'd3), .MAX_STEPS(4)) dut (
    .clock(clock), .Reset_n(Reset_n),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .step(step), .run(run), .restart(restart),
    .next_state_out(next_state_out), .direction(direction), .data_reg_out(data_reg_out),
    .tm_reset(tm_reset), .input_data(input_data), .Next(Next), .Done(Done),
    .state_q(state_q), .dir_q(dir_q), .tape_q(tape_q),
    .prog_count(prog_count), .step_count(step_count),
    .halted(halted), .timeout(timeout), .busy(busy)
  );

  // Core model: captures a nibble on each load-phase Next rise, switches to run on
  // Done, and executes one step on each run-phase Next fall. Entry for
  // (state[1:0], tape[head]) is 4 nibbles: write bit, next state, unused, direction.
  logic [3:0] m_prog [32];
  logic [5:0] m_state = '0, m_tape = '0;
  logic [2:0] m_head = '0;
  logic [1:0] m_dir = '0;
  logic [4:0] m_pi = '0;
  logic       m_run = 1'b0, nxt_prev = 1'b0, done_prev = 1'b0;
  int         done_rises = 0;
  logic [2:0] m_e;
  logic       m_w;
  logic [3:0] m_ns;
  logic [1:0] m_d;

  assign m_e  = {m_state[1:0], m_tape[m_head]};
  assign m_w  = m_prog[{m_e, 2'b00}][0];
  assign m_ns = m_prog[{m_e, 2'b01}];
  assign m_d  = m_prog[{m_e, 2'b11}][1:0];
  assign next_state_out = m_state;
  assign direction      = m_dir;
  assign data_reg_out   = m_tape;

  always @(posedge clock) begin
    nxt_prev  <= Next;
    done_prev <= Done;
    if (Done && !done_prev) done_rises <= done_rises + 1;
    if (tm_reset) begin
      m_state <= '0; m_tape <= '0; m_head <= '0; m_dir <= '0; m_pi <= '0; m_run <= 1'b0;
    end else begin
      if (Next && !nxt_prev && !m_run) begin
        m_prog[m_pi] <= input_data;
        m_pi <= m_pi + 5'd1;
      end
      if (Done && !done_prev) m_run <= 1'b1;
      if (!Next && nxt_prev && m_run) begin
        m_tape[m_head] <= m_w;
        m_state <= {2'b00, m_ns};
        m_dir <= m_d;
        if (m_d == 2'd2) m_head <= (m_head == 3'd5) ? m_head : m_head + 3'd1;
        else if (m_d == 2'd1) m_head <= (m_head == 3'd0) ? m_head : m_head - 3'd1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic send_nibble(input logic [3:0] d);
    int n = 0;
    @(negedge clock);
    while (!load_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ready_wait: load_ready=%b required 1", load_ready);
    end
    load_valid = 1'b1;
    load_data  = d;
    @(posedge clock);
    #1 load_valid = 1'b0;
  endtask

  task automatic wait_ready_state();
    int n = 0;
    @(posedge clock); #1;
    while (!(busy === 1'b0 && load_ready === 1'b0) && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (busy !== 1'b0 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL reach_ready: busy=%b load_ready=%b required 0 0", busy, load_ready);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({tm_reset, Next, Done, load_ready, halted, timeout, busy} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 1000000",
               {tm_reset, Next, Done, load_ready, halted, timeout, busy});
    end
    checks++;
    if ({prog_count, step_count, state_q, dir_q, tape_q, input_data} !== '0) begin
      errors++;
      $display("FAIL reset_regs: prog=%0d steps=%0d state=%0d dir=%0d tape=%0d in=%0d required 0",
               prog_count, step_count, state_q, dir_q, tape_q, input_data);
    end
    @(negedge clock) Reset_n = 1'b1;
    @(posedge clock); #1;
    checks++;
    if ({tm_reset, load_ready} !== 2'b10) begin
      errors++;
      $display("FAIL tm_reset_cycle2: tm_reset=%b load_ready=%b required 1 0", tm_reset, load_ready);
    end
    @(posedge clock); #1;
    checks++;
    if ({tm_reset, load_ready, Next, Done, prog_count, step_count} !== {4'b0100, 14'd0}) begin
      errors++;
      $display("FAIL tm_reset_release: tm_reset=%b load_ready=%b Next=%b Done=%b prog=%0d steps=%0d required 0 1 0 0 0 0",
               tm_reset, load_ready, Next, Done, prog_count, step_count);
    end
  endtask

  // Accept edge is 0; Next is high in the cycles following edges 3 and 4.
  task automatic test_single_nibble();
    logic [5:0] exp;
    send_nibble(4'd3);
    checks++;
    if ({input_data, prog_count, load_ready, Next, busy} !== {4'd3, 6'd1, 3'b001}) begin
      errors++;
      $display("FAIL nibble_accept: in=%0d prog=%0d ready=%b Next=%b busy=%b required 3 1 0 0 1",
               input_data, prog_count, load_ready, Next, busy);
    end
    for (int k = 1; k <= 7; k++) begin
      @(posedge clock); #1;
      exp = {(k == 3 || k == 4) ? 1'b1 : 1'b0, (k == 7) ? 1'b1 : 1'b0, 4'd3};
      checks++;
      if ({Next, load_ready, input_data} !== exp) begin
        errors++;
        $display("FAIL nibble_timing_%0d: Next/ready/in=%b required %b", k,
                 {Next, load_ready, input_data}, exp);
      end
    end
  endtask

  task automatic test_restart_mid_load();
    int n = 0;
    for (int i = 2; i <= 10; i++) send_nibble(4'(i));
    checks++;
    if (prog_count !== 6'd10) begin
      errors++;
      $display("FAIL prog_count_10: got %0d required 10", prog_count);
    end
    while (Next !== 1'b1 && n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (Next !== 1'b1) begin
      errors++;
      $display("FAIL nibble10_pulse: Next=%b required 1", Next);
    end
    @(negedge clock) restart = 1'b1;
    @(posedge clock); #1 restart = 1'b0;
    checks++;
    if ({Next, Done, tm_reset, busy, prog_count, input_data} !== {4'b0011, 6'd0, 4'd0}) begin
      errors++;
      $display("FAIL restart_drop: Next=%b Done=%b tm_reset=%b busy=%b prog=%0d in=%0d required 0 0 1 1 0 0",
               Next, Done, tm_reset, busy, prog_count, input_data);
    end
    @(posedge clock); #1;
    @(posedge clock); #1;
    checks++;
    if ({tm_reset, load_ready} !== 2'b01) begin
      errors++;
      $display("FAIL restart_release: tm_reset=%b load_ready=%b required 0 1", tm_reset, load_ready);
    end
  endtask

  task automatic test_full_load(input logic [3:0] tbl [32], input int exp_done_rises);
    int done_cnt = 0, first_done = -1, overlap = 0;
    for (int i = 0; i < 32; i++) send_nibble(tbl[i]);
    for (int k = 1; k <= 11; k++) begin
      @(posedge clock); #1;
      if (Done === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
      end
      if (Done === 1'b1 && (Next === 1'b1 || tm_reset === 1'b1)) overlap++;
    end
    checks++;
    if (done_cnt != 2 || first_done != 7 || overlap != 0) begin
      errors++;
      $display("FAIL done_pulse: cycles=%0d first_edge=%0d overlap=%0d required 2 7 0",
               done_cnt, first_done, overlap);
    end
    checks++;
    if ({busy, load_ready, prog_count} !== {2'b00, 6'd32}) begin
      errors++;
      $display("FAIL ready_after_load: busy=%b ready=%b prog=%0d required 0 0 32",
               busy, load_ready, prog_count);
    end
    checks++;
    if (done_rises != exp_done_rises) begin
      errors++;
      $display("FAIL done_rise_count: got %0d required %0d", done_rises, exp_done_rises);
    end
  endtask

  task automatic test_single_step();
    @(negedge clock) step = 1'b1;
    @(posedge clock); #1 step = 1'b0;
    checks++;
    if ({Next, busy} !== 2'b11) begin
      errors++;
      $display("FAIL step_pulse: Next=%b busy=%b required 1 1", Next, busy);
    end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clock); #1;
      if (k == 5) begin
        checks++;
        if ({state_q, step_count} !== 14'd0) begin
          errors++;
          $display("FAIL step_early: state=%0d steps=%0d required 0 0", state_q, step_count);
        end
      end
    end
    checks++;
    if ({state_q, dir_q, tape_q, step_count, busy, halted} !== {6'd1, 2'd2, 6'b000001, 8'd1, 2'b00}) begin
      errors++;
      $display("FAIL single_step: state=%0d dir=%0d tape=%b steps=%0d busy=%b halted=%b required 1 2 000001 1 0 0",
               state_q, dir_q, tape_q, step_count, busy, halted);
    end
  endtask

  task automatic test_run_halt();
    int n = 0;
    @(negedge clock) run = 1'b1;
    @(posedge clock); #1 run = 1'b0;
    while (!(halted === 1'b1 || timeout === 1'b1) && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if ({halted, timeout, state_q, dir_q, tape_q, step_count} !==
        {2'b10, 6'd3, 2'd1, 6'b000001, 8'd2}) begin
      errors++;
      $display("FAIL run_halt: halted=%b timeout=%b state=%0d dir=%0d tape=%b steps=%0d required 1 0 3 1 000001 2",
               halted, timeout, state_q, dir_q, tape_q, step_count);
    end
    @(negedge clock) begin step = 1'b1; run = 1'b1; end
    repeat (3) @(posedge clock);
    #1 begin step = 1'b0; run = 1'b0; end
    checks++;
    if ({halted, Next, busy, step_count} !== {3'b100, 8'd2}) begin
      errors++;
      $display("FAIL halted_hold: halted=%b Next=%b busy=%b steps=%0d required 1 0 0 2",
               halted, Next, busy, step_count);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] zeros [32];
    int t[2] = '{-1, -1};
    int e = 0, nchg = 0;
    logic [7:0] prev;
    for (int i = 0; i < 32; i++) zeros[i] = 4'd0;
    @(negedge clock) restart = 1'b1;
    @(posedge clock); #1 restart = 1'b0;
    checks++;
    if ({halted, timeout, step_count, prog_count} !== {2'b00, 8'd0, 6'd0}) begin
      errors++;
      $display("FAIL restart_clear: halted=%b timeout=%b steps=%0d prog=%0d required 0 0 0 0",
               halted, timeout, step_count, prog_count);
    end
    for (int i = 0; i < 32; i++) send_nibble(zeros[i]);
    wait_ready_state();
    @(negedge clock) run = 1'b1;
    @(posedge clock); #1 run = 1'b0;
    prev = step_count;
    while (!(halted === 1'b1 || timeout === 1'b1) && e < 100) begin
      @(posedge clock); #1;
      e++;
      if (step_count !== prev) begin
        if (nchg < 2) t[nchg] = e;
        nchg++;
        prev = step_count;
      end
    end
    checks++;
    if ({timeout, halted, step_count, state_q, tape_q} !== {2'b10, 8'd4, 6'd0, 6'd0}) begin
      errors++;
      $display("FAIL run_timeout: timeout=%b halted=%b steps=%0d state=%0d tape=%b required 1 0 4 0 000000",
               timeout, halted, step_count, state_q, tape_q);
    end
    checks++;
    if (t[0] != 6 || t[1] - t[0] != 6) begin
      errors++;
      $display("FAIL auto_period: first=%0d period=%0d required 6 6", t[0], t[1] - t[0]);
    end
  endtask

  initial begin
    logic [3:0] table_a [32];
    table_a = '{4'd3, 4'd1, 4'd1, 4'd2, 4'd1, 4'd1, 4'd1, 4'd0,
                4'd0, 4'd3, 4'd1, 4'd1, 4'd2, 4'd0, 4'd2, 4'd3,
                4'd0, 4'd0, 4'd3, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0,
                4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    test_reset();
    test_single_nibble();
    test_restart_mid_load();
    test_full_load(table_a, 1);
    test_single_step();
    test_run_halt();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
